// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light controller: lamp codes, phase encodes
// and default dwell times.
package tlc_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef enum logic [2:0] {
    ST_S1 = 3'd0,
    ST_S2 = 3'd1,
    ST_S3 = 3'd2,
    ST_S4 = 3'd3,
    ST_S5 = 3'd4,
    ST_S6 = 3'd5,
    ST_S7 = 3'd6
  } tlc_state_e;

  localparam int T_MAIN_DEF   = 7;
  localparam int T_TURN_DEF   = 5;
  localparam int T_SIDE_DEF   = 3;
  localparam int T_YEL_DEF    = 2;
  localparam int T_ALLRED_DEF = 2;
  localparam int CW_DEF       = 4;

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase dwell counter: looks up the dwell of the current phase and flags
// the last cycle of it. Honours TLC_ALL_RED_EN for the all-red phase.
module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int T_MAIN   = T_MAIN_DEF,
  parameter int T_TURN   = T_TURN_DEF,
  parameter int T_SIDE   = T_SIDE_DEF,
  parameter int T_YEL    = T_YEL_DEF,
  parameter int T_ALLRED = T_ALLRED_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    state_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] last_count;
  logic          valid;
  int            dwell;

  always_comb begin
    dwell = 1;
    valid = 1'b1;
    case (state_i)
      ST_S1: dwell = T_MAIN;
      ST_S2: dwell = T_YEL;
      ST_S3: dwell = T_TURN;
      ST_S4: dwell = T_YEL;
      ST_S5: dwell = T_SIDE;
      ST_S6: dwell = T_YEL;
      ST_S7: begin
        dwell = T_ALLRED;
`ifndef TLC_ALL_RED_EN
        valid = 1'b0;
`endif
      end
      default: valid = 1'b0;
    endcase
  end

  assign last_count = CW'(dwell - 1);
  assign tc_o       = valid && (count_q == last_count);

  // An unused encode is recovering to S1, so the count restarts with it.
  always_comb begin
    count_d = count_q + 1'b1;
    if (tc_o || !valid) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_light_controller.sv
// Moore FSM stepping a fixed six-phase junction cycle (seven with the all-red
// phase when TLC_ALL_RED_EN is defined); lamps decode the registered state.
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int T_MAIN   = T_MAIN_DEF,
  parameter int T_TURN   = T_TURN_DEF,
  parameter int T_SIDE   = T_SIDE_DEF,
  parameter int T_YEL    = T_YEL_DEF,
  parameter int T_ALLRED = T_ALLRED_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] M1,
  output logic [2:0] MT,
  output logic [2:0] M2,
  output logic [2:0] S
);

  tlc_state_e    current_state;
  tlc_state_e    next_state;
  logic [CW-1:0] count;
  logic          tc;

  tlc_phase_timer #(
    .T_MAIN  (T_MAIN),
    .T_TURN  (T_TURN),
    .T_SIDE  (T_SIDE),
    .T_YEL   (T_YEL),
    .T_ALLRED(T_ALLRED),
    .CW      (CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .state_i(current_state),
    .count_o(count),
    .tc_o   (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) current_state <= ST_S1;
    else     current_state <= next_state;
  end

  always_comb begin
    next_state = current_state;
    case (current_state)
      ST_S1: if (tc) next_state = ST_S2;
      ST_S2: if (tc) next_state = ST_S3;
      ST_S3: if (tc) next_state = ST_S4;
      ST_S4: if (tc) next_state = ST_S5;
      ST_S5: if (tc) next_state = ST_S6;
`ifdef TLC_ALL_RED_EN
      ST_S6: if (tc) next_state = ST_S7;
      ST_S7: if (tc) next_state = ST_S1;
`else
      ST_S6: if (tc) next_state = ST_S1;
`endif
      default: next_state = ST_S1;
    endcase
  end

  // All-red is both the S7 pattern and the safe decode for unused encodes.
  always_comb begin
    M1 = LAMP_RED;
    MT = LAMP_RED;
    M2 = LAMP_RED;
    S  = LAMP_RED;
    case (current_state)
      ST_S1: begin M1 = LAMP_GREEN;  M2 = LAMP_GREEN;  end
      ST_S2: begin M1 = LAMP_GREEN;  M2 = LAMP_YELLOW; end
      ST_S3: begin M1 = LAMP_GREEN;  MT = LAMP_GREEN;  end
      ST_S4: begin M1 = LAMP_YELLOW; MT = LAMP_YELLOW; end
      ST_S5: S = LAMP_GREEN;
      ST_S6: S = LAMP_YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench: a phase/duration table model predicts lamps, state and
// count from the number of clock edges since reset release.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] M1, MT, M2, S;

  traffic_light_controller dut (
    .clk(clk),
    .rst(rst),
    .M1 (M1),
    .MT (MT),
    .M2 (M2),
    .S  (S)
  );

  always #5 clk = ~clk;

`ifdef TLC_ALL_RED_EN
  localparam int NPH = 7;
`else
  localparam int NPH = 6;
`endif

  int          dur[7] = '{7, 2, 5, 2, 3, 2, 2};
  logic [11:0] pat[7] = '{12'b001_100_001_100, 12'b001_100_010_100,
                          12'b001_001_100_100, 12'b010_010_100_100,
                          12'b100_100_100_001, 12'b100_100_100_010,
                          12'b100_100_100_100};
  int period;
  int n;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model(input int k, output int ph, output int cnt);
    int p;
    p  = k % period;
    ph = 0;
    while (p >= dur[ph]) begin
      p -= dur[ph];
      ph++;
    end
    cnt = p;
  endtask

  task automatic check_all(input string ctx);
    int ph, cnt;
    logic ok;
    model(n, ph, cnt);
    chk({ctx, "_lamps"}, 32'({M1, MT, M2, S}), 32'(pat[ph]));
    chk({ctx, "_state"}, 32'(dut.current_state), 32'(ph));
    chk({ctx, "_count"}, 32'(dut.count), 32'(cnt));
    ok = $onehot(M1) && $onehot(MT) && $onehot(M2) && $onehot(S);
    chk({ctx, "_onehot"}, 32'(ok), 32'd1);
    $display("edge %0d %s: M1=%b MT=%b M2=%b S=%b phase=%0d count=%0d",
             n, ctx, M1, MT, M2, S, ph, cnt);
  endtask

  task automatic run(input int cycles, input string ctx);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      n++;
      check_all(ctx);
    end
  endtask

  task automatic async_reset(input int delay, input string ctx);
    #(delay);
    rst = 1'b1;
    n   = 0;
    #1;
    check_all({ctx, "_immediate"});
    @(posedge clk);
    #1;
    check_all({ctx, "_held"});
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
  endtask

  initial begin
    int ph, cnt, found;
    period = 0;
    for (int i = 0; i < NPH; i++) period += dur[i];

    rst = 1'b1;
    n   = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    run(period, "first_cycle");
    run(120, "long_run");

    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      model(n, ph, cnt);
      if (ph == 2 && cnt == 2) found = 1;
      else run(1, "seek_s3");
    end
    chk("reach_mid_s3", 32'(found), 32'd1);
    async_reset(2, "rst_mid_s3");
    run(8, "after_rst_s1");

    for (int e = 0; e < 6; e++) begin
      run($urandom_range(1, 45), "rand_run");
      async_reset($urandom_range(1, 7), "rand_rst");
      run($urandom_range(1, 10), "rand_post");
    end

    run(period + 3, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
